// File: rtl/chat_log_buffer_pkg.sv
// Shared constants, prefixes and state encodings for the chat log buffer.
package chat_pkg;
    localparam int NLINES_DEF = 12;
    localparam int NCHAR_DEF  = 15;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] ESC   = 8'h1B;

    localparam logic [55:0] PREFIX_U1 = "User1: ";
    localparam logic [55:0] PREFIX_U2 = "User2: ";

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        FLUSH  = 2'd2
    } state_t;
endpackage

// File: rtl/chat_line_ram.sv
// Line storage for the chat log: one synchronous write port and one
// registered read port that can be forced to a blank line.
module chat_line_ram
    import chat_pkg::*;
#(
    parameter int NLINES = NLINES_DEF,
    parameter int NCHAR  = NCHAR_DEF,
    parameter int AW     = 4
) (
    input  logic               clock_65mhz,
    input  logic               reset_n,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [NCHAR*8-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    input  logic               rblank,
    output logic [NCHAR*8-1:0] rdata
);
    localparam logic [NCHAR*8-1:0] BLANK = {NCHAR{SPACE}};

    logic [NCHAR*8-1:0] mem [NLINES];

    always_ff @(posedge clock_65mhz) begin
        if (we) mem[waddr] <= wdata;
    end

    // Reads sample mem before a same-edge write lands.
    always_ff @(posedge clock_65mhz or negedge reset_n) begin
        if (!reset_n) rdata <= BLANK;
        else          rdata <= rblank ? BLANK : mem[raddr];
    end
endmodule

// File: rtl/chat_log_buffer.sv
// Chat line assembler with circular line log and live edit line.
// Optional: define CHATLOG_CLEAR_EN to make ESC clear the whole log.
module chat_log_buffer
    import chat_pkg::*;
#(
    parameter int NLINES     = NLINES_DEF,
    parameter int NCHAR      = NCHAR_DEF,
    parameter int PREFIX_LEN = 7,
    parameter int MSG_LEN    = NCHAR - PREFIX_LEN,
    parameter int IDX_BITS   = 4
) (
    input  logic                 clock_65mhz,
    input  logic                 reset_n,
    input  logic                 char_valid,
    input  logic [7:0]           char_data,
    input  logic                 char_user,
    output logic                 char_ready,
    input  logic [IDX_BITS-1:0]  rd_index,
    output logic [NCHAR*8-1:0]   rd_line,
    output logic [IDX_BITS-1:0]  line_count,
    output logic [MSG_LEN*8-1:0] edit_line,
    output logic [IDX_BITS-1:0]  edit_len,
    output logic                 overflow
);
    localparam int PW = $clog2(MSG_LEN);
    localparam logic [IDX_BITS-1:0] LAST    = IDX_BITS'(NLINES - 1);
    localparam logic [IDX_BITS-1:0] FULL    = IDX_BITS'(NLINES);
    localparam logic [IDX_BITS-1:0] MAX_LEN = IDX_BITS'(MSG_LEN);
    localparam logic [IDX_BITS:0]   NL_W    = (IDX_BITS+1)'(NLINES);

    state_t              state;
    logic [IDX_BITS-1:0] head;
    logic [IDX_BITS-1:0] tail;
    logic                cur_user;
    logic [7:0]          msg [MSG_LEN];

    logic                switch_req;
    logic                accept;
    logic                printable;
    logic                we;
    logic [NCHAR*8-1:0]  wr_line;
    logic [IDX_BITS:0]   rd_sum;
    logic [IDX_BITS-1:0] rd_addr;
    logic                rd_blank;

    for (genvar g = 0; g < MSG_LEN; g++) begin : g_pack
        assign edit_line[(MSG_LEN-1-g)*8 +: 8] = msg[g];
    end

    // A different sender mid-line stalls the character and flushes first.
    assign switch_req = char_valid && (edit_len != '0)
                        && (char_user != cur_user);
    assign char_ready = (state == IDLE) && !switch_req;
    assign accept     = char_valid && char_ready;
    assign printable  = (char_data >= 8'h20) && (char_data <= 8'h7E);

    assign we      = (state == COMMIT) || (state == FLUSH);
    assign wr_line = {cur_user ? PREFIX_U2 : PREFIX_U1, edit_line};

    assign rd_sum   = {1'b0, head} + {1'b0, rd_index};
    assign rd_addr  = (rd_sum >= NL_W) ? IDX_BITS'(rd_sum - NL_W)
                                       : IDX_BITS'(rd_sum);
    assign rd_blank = rd_index >= line_count;

    always_ff @(posedge clock_65mhz or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            line_count <= '0;
            edit_len   <= '0;
            cur_user   <= 1'b0;
            overflow   <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) msg[i] <= SPACE;
        end else begin
            overflow <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (switch_req) begin
                        state <= FLUSH;
                    end else if (accept) begin
                        unique case (1'b1)
                            printable: begin
                                if (edit_len < MAX_LEN) begin
                                    msg[PW'(edit_len)] <= char_data;
                                    edit_len <= edit_len + 1'b1;
                                    if (edit_len == '0) cur_user <= char_user;
                                end else begin
                                    overflow <= 1'b1;
                                end
                            end
                            char_data == BS: begin
                                if (edit_len != '0) begin
                                    msg[PW'(edit_len - 1'b1)] <= SPACE;
                                    edit_len <= edit_len - 1'b1;
                                end
                            end
                            char_data == CR: begin
                                if (edit_len != '0) state <= COMMIT;
                            end
`ifdef CHATLOG_CLEAR_EN
                            char_data == ESC: begin
                                head       <= '0;
                                tail       <= '0;
                                line_count <= '0;
                                edit_len   <= '0;
                                for (int i = 0; i < MSG_LEN; i++) msg[i] <= SPACE;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                COMMIT, FLUSH: begin
                    tail <= (tail == LAST) ? '0 : tail + 1'b1;
                    if (line_count < FULL) line_count <= line_count + 1'b1;
                    else head <= (head == LAST) ? '0 : head + 1'b1;
                    edit_len <= '0;
                    for (int i = 0; i < MSG_LEN; i++) msg[i] <= SPACE;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    chat_line_ram #(
        .NLINES (NLINES),
        .NCHAR  (NCHAR),
        .AW     (IDX_BITS)
    ) u_ram (
        .clock_65mhz (clock_65mhz),
        .reset_n     (reset_n),
        .we          (we),
        .waddr       (tail),
        .wdata       (wr_line),
        .raddr       (rd_addr),
        .rblank      (rd_blank),
        .rdata       (rd_line)
    );
endmodule

// File: tb/tb_chat_log_buffer.sv
// Directed scoreboard bench for chat_log_buffer.
// Covers append, overflow, backspace, commit, sender switch, wrap, reset.
module tb_chat_log_buffer;
    import chat_pkg::*;

    localparam logic [119:0] BLANK_LINE = {15{8'h20}};
    localparam logic [63:0]  BLANK_EDIT = {8{8'h20}};

    logic         clock_65mhz = 1'b0;
    logic         reset_n;
    logic         char_valid;
    logic [7:0]   char_data;
    logic         char_user;
    logic         char_ready;
    logic [3:0]   rd_index;
    logic [119:0] rd_line;
    logic [3:0]   line_count;
    logic [63:0]  edit_line;
    logic [3:0]   edit_len;
    logic         overflow;

    int passed   = 0;
    int total    = 0;
    int ovf_seen = 0;

    logic [119:0] model [$];
    logic [119:0] exp_q [$];

    always #8 clock_65mhz = ~clock_65mhz;

    chat_log_buffer dut (
        .clock_65mhz (clock_65mhz),
        .reset_n     (reset_n),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_user   (char_user),
        .char_ready  (char_ready),
        .rd_index    (rd_index),
        .rd_line     (rd_line),
        .line_count  (line_count),
        .edit_line   (edit_line),
        .edit_len    (edit_len),
        .overflow    (overflow)
    );

    function automatic logic [63:0] mk_edit(input string p);
        logic [63:0] r;
        r = BLANK_EDIT;
        for (int i = 0; i < 8; i++)
            if (i < p.len()) r[(7-i)*8 +: 8] = p[i];
        return r;
    endfunction

    function automatic logic [119:0] mk_line(input logic u, input string p);
        logic [55:0] pf;
        pf = u ? "User2: " : "User1: ";
        return {pf, mk_edit(p)};
    endfunction

    task automatic chk(input string tag, input logic [119:0] obs,
                       input logic [119:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock_65mhz);
        #1;
    endtask

    task automatic send(input logic u, input logic [7:0] d);
        int n = 0;
        char_valid = 1'b1;
        char_data  = d;
        char_user  = u;
        @(negedge clock_65mhz);
        while (!char_ready && n < 8) begin
            @(negedge clock_65mhz);
            n++;
        end
        chk("ready_wait", 120'(n < 8), 120'd1);
        tick();
        char_valid = 1'b0;
        if (overflow) ovf_seen++;
    endtask

    task automatic send_str(input logic u, input string s);
        for (int i = 0; i < s.len(); i++) send(u, s[i]);
    endtask

    task automatic push_model(input logic [119:0] l);
        model.push_back(l);
        if (model.size() > 12) void'(model.pop_front());
    endtask

    task automatic commit(input logic u, input string s);
        send_str(u, s);
        send(u, CR);
        tick();
        push_model(mk_line(u, s));
    endtask

    task automatic read(input logic [3:0] idx, input logic [119:0] exp,
                        input string tag);
        rd_index = idx;
        exp_q.push_back(exp);
        tick();
        chk(tag, rd_line, exp_q.pop_front());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   exp_lc;
        logic [3:0]   exp_el;
        logic [119:0] exp_r0;

        reset_n    = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        char_user  = 1'b0;
        rd_index   = 4'd0;
        repeat (3) tick();
        chk("rst_line_count", line_count, 0);
        chk("rst_edit_len", edit_len, 0);
        chk("rst_edit_line", edit_line, BLANK_EDIT);
        chk("rst_rd_line", rd_line, BLANK_LINE);
        chk("rst_overflow", overflow, 0);
        chk("rst_ready", char_ready, 1);
        @(negedge clock_65mhz);
        reset_n = 1'b1;
        tick();

        // first line, with a read issued during the commit cycle
        send_str(0, "3AAA5678");
        chk("full_len", edit_len, 8);
        chk("full_edit", edit_line, mk_edit("3AAA5678"));
        send(0, CR);
        rd_index = 4'd0;
        exp_q.push_back(BLANK_LINE);
        chk("commit_stall", char_ready, 0);
        tick();
        chk("rd_precommit", rd_line, exp_q.pop_front());
        chk("commit_ready", char_ready, 1);
        chk("count_1", line_count, 1);
        push_model(mk_line(0, "3AAA5678"));
        read(0, mk_line(0, "3AAA5678"), "rd_line1");

        // overflow and backspace
        ovf_seen = 0;
        send_str(0, "ABCDEFGHIJ");
        chk("ovf_len", edit_len, 8);
        chk("ovf_edit", edit_line, mk_edit("ABCDEFGH"));
        chk("ovf_pulses", ovf_seen, 2);
        tick();
        chk("ovf_clear", overflow, 0);
        repeat (3) send(0, BS);
        chk("bs_edit", edit_line, mk_edit("ABCDE"));
        chk("bs_len", edit_len, 5);
        send(0, CR);
        tick();
        push_model(mk_line(0, "ABCDE"));
        chk("count_2", line_count, 2);

        // CR and BS on an empty line do nothing
        ovf_seen = 0;
        send(0, CR);
        chk("empty_cr_ready", char_ready, 1);
        send(0, BS);
        chk("empty_count", line_count, 2);
        chk("empty_len", edit_len, 0);
        chk("empty_edit", edit_line, BLANK_EDIT);
        chk("empty_ovf", ovf_seen, 0);

        // sender switch flushes the partial line
        send_str(0, "HI");
        char_valid = 1'b1;
        char_user  = 1'b1;
        char_data  = "Y";
        @(negedge clock_65mhz);
        chk("switch_stall", char_ready, 0);
        send(1, "Y");
        push_model(mk_line(0, "HI"));
        chk("switch_count", line_count, 3);
        chk("switch_edit", edit_line, mk_edit("Y"));
        chk("switch_len", edit_len, 1);
        send(1, CR);
        tick();
        push_model(mk_line(1, "Y"));
        for (int i = 0; i < 5; i++)
            read(4'(i), (i < model.size()) ? model[i] : BLANK_LINE, "rd_log");

        // reset during a commit cycle
        send_str(0, "Z");
        send(0, CR);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_count", line_count, 0);
        chk("arst_len", edit_len, 0);
        chk("arst_edit", edit_line, BLANK_EDIT);
        chk("arst_rd", rd_line, BLANK_LINE);
        chk("arst_ready", char_ready, 1);
        @(negedge clock_65mhz);
        reset_n = 1'b1;
        model.delete();
        tick();

        // 13 lines wrap the 12-line log
        for (int n = 1; n <= 13; n++) commit(0, $sformatf("LINE%0d", n));
        chk("wrap_count", line_count, 12);
        read(0, mk_line(0, "LINE2"), "wrap_oldest");
        read(11, mk_line(0, "LINE13"), "wrap_newest");
        read(12, BLANK_LINE, "wrap_beyond");
        read(15, BLANK_LINE, "wrap_max_idx");
        read(5, model[5], "wrap_mid");

        // ESC: clears the log only when the clear feature is built in
        send(0, "Q");
        send(0, ESC);
`ifdef CHATLOG_CLEAR_EN
        exp_lc = 4'd0;
        exp_el = 4'd0;
        exp_r0 = BLANK_LINE;
`else
        exp_lc = 4'd12;
        exp_el = 4'd1;
        exp_r0 = mk_line(0, "LINE2");
`endif
        chk("esc_count", line_count, exp_lc);
        chk("esc_len", edit_len, exp_el);
        chk("esc_ready", char_ready, 1);
        read(0, exp_r0, "esc_rd");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
